bargraph_rx: RTL and testbench
==============================

// Module: bargraph_rx
// PURPOSE
//  Receive-side decoder for the RGB bar graph serial interface (blank/row/col/sclk/latch).
//  Oversamples the five interface pins in the clk domain and deserialises col bits on sclk rising edges.
//  On each latch rising edge, presents one row word tagged with the row index.
//  Used for hardware loopback and self-check of the bar graph driver, and as a bench monitor.
// PARAMETERS
//  COLUMN_BITS  48  shift-chain length per row, i.e. bits expected between latches
//  CNT_W        16  width of stats counters (used only with BARGRAPH_RX_STATS_EN)
// PORTS
//  clk          in   1            single system clock; must be >= 4x sclk frequency
//  rst          in   1            synchronous, active-high reset
//  bg_blank     in   1            async pin: display blank
//  bg_row       in   4            async pin: row select
//  bg_col       in   1            async pin: serial column data
//  bg_sclk      in   1            async pin: shift clock
//  bg_latch     in   1            async pin: latch strobe
//  row_valid    out  1            1-cycle pulse: row_* fields valid
//  row_idx      out  4            row index captured at latch
//  row_data     out  COLUMN_BITS  deserialised row; first-shifted bit lands in MSB
//  row_len_err  out  1            bit count since previous latch != COLUMN_BITS
//  row_blanked  out  1            synced blank was high at latch
//  frame_start  out  1            pulses with row_valid when row_idx == 0
//  active       out  1            high in S_SHIFT
//  frame_cnt    out  CNT_W        frames seen (stats)
//  err_cnt      out  CNT_W        rows with len_err (stats)
// BEHAVIOUR
//  - Reset: all outputs 0, shift reg and bit_cnt cleared, state S_IDLE, synchronisers cleared.
//  - Sync: every input passes 2 flops, then 1 history flop for edge detection.
//    Rise strobes = sync & ~hist. Pin edge to internal strobe: 3 clk.
//  - Shift: on sclk_rise, sr <= {sr[COLUMN_BITS-2:0], col_sync}.
//    bit_cnt saturates at COLUMN_BITS+1.
//    More than COLUMN_BITS bits: keep the last COLUMN_BITS and flag len_err.
//  - Latch: on latch_rise, row_data <= sr, row_idx <= row_sync, row_blanked <= blank_sync,
//    row_len_err <= (bit_cnt != COLUMN_BITS), row_valid = 1 for one cycle.
//    Then sr and bit_cnt clear. Pin latch edge to row_valid: 4 clk.
//  - Fewer bits than COLUMN_BITS: row_data holds the received bits right-aligned,
//    upper bits 0, len_err = 1.
//  - Latch with zero bits: row_valid still fires, row_data = 0, len_err = 1.
//  - sclk_rise and latch_rise in the same cycle: the shift is applied first;
//    the latched word includes that bit.
//  - FSM:
//    S_IDLE  -> S_SHIFT on sclk_rise.
//    S_SHIFT -> S_IDLE on latch_rise.
//    A latch_rise in S_IDLE emits a row directly (zero-bit case).
//  - Outputs are registered; row_* fields hold until the next row_valid.
//  - Reset mid-row: partial row discarded, no row_valid emitted; the next row starts clean.
// CONFIGURATION
//  BARGRAPH_RX_STATS_EN defined:
//    - frame_cnt increments on frame_start.
//    - err_cnt increments on row_valid & row_len_err.
//    - Both wrap at 2^CNT_W, both cleared by rst.
//  BARGRAPH_RX_STATS_EN undefined: frame_cnt and err_cnt tied to 0, no counter logic.
// STRUCTURE
//  Package bargraph_pkg:
//    - ROW_W = 4, COLUMN_BITS_DEF = 48
//    - typedef enum logic {S_IDLE, S_SHIFT} rx_state_t
//    - typedef struct for the row output bundle
//  Sub-module bargraph_sync: parameterised WIDTH.
//    Outputs 2-flop sync plus rise strobe; instanced once for {blank, row, col, sclk, latch}.
// TESTING
//  1. 48 bits of 0xA5A5_0000_FFFF, MSB first, row=3, then latch
//     -> row_valid once, row_idx=3, row_data=0xA5A5_0000_FFFF, len_err=0.
//  2. 40 bits all 1s then latch -> row_data=0x00FF_FFFF_FFFF, len_err=1.
//     With STATS: err_cnt=1.
//  3. 50 bits: 2 zeros then 48 ones -> row_data all 1s, len_err=1.
//  4. Latch with no sclk -> row_valid, row_data=0, len_err=1.
//     sclk and latch coincident on the 48th bit -> bit included, len_err=0.
//  5. Rows 0..15 twice, blank high on row 5
//     -> frame_start on both row 0s, row_blanked only on row 5; STATS: frame_cnt=2.
//  6. rst asserted after 20 bits, then full 48-bit row
//     -> no row_valid during reset, next row correct, len_err=0.

Source files
------------

// File: rtl/bargraph_pkg.sv
// Shared types and constants for the bar graph serial receiver.
package bargraph_pkg;

   localparam int ROW_W           = 4;
   localparam int COLUMN_BITS_DEF = 48;
   // Pin bundle order: {blank, row[3:0], col, sclk, latch}
   localparam int PIN_W           = ROW_W + 4;
   localparam int PIN_LATCH       = 0;
   localparam int PIN_SCLK        = 1;
   localparam int PIN_COL         = 2;
   localparam int PIN_ROW_LO      = 3;
   localparam int PIN_BLANK       = PIN_ROW_LO + ROW_W;

   typedef enum logic {S_IDLE, S_SHIFT} rx_state_t;

   // Per-row side information presented alongside row_data
   typedef struct packed {
      logic             valid;
      logic             frame_start;
      logic [ROW_W-1:0] idx;
      logic             len_err;
      logic             blanked;
   } row_meta_t;

endpackage

// File: rtl/bargraph_sync.sv
// Two-flop synchroniser with a history flop and registered rise strobe.
// sync_o is the history flop so the level is cycle-aligned with rise_o:
// a pin edge shows up on both outputs 3 clk later.
module bargraph_sync #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] async_i,
   output logic [WIDTH-1:0] sync_o,
   output logic [WIDTH-1:0] rise_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] hist_q;
   logic [WIDTH-1:0] rise_q;

   // Synchronise, keep one cycle of history, register the rising-edge strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
         hist_q <= '0;
         rise_q <= '0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
         hist_q <= sync_q;
         rise_q <= sync_q & ~hist_q;
      end
   end

   assign sync_o = hist_q;
   assign rise_o = rise_q;

endmodule

// File: rtl/bargraph_rx.sv
// Receive-side decoder for the RGB bar graph serial interface.
// Deserialises col on sclk rising edges and emits one row word per latch.
// Optional statistics counters are built when BARGRAPH_RX_STATS_EN is defined.
// Handshake: row_valid is a one-cycle pulse with no back-pressure; row_* fields
// hold their value until the next row_valid.
module bargraph_rx
   import bargraph_pkg::*;
#(
   parameter int COLUMN_BITS = COLUMN_BITS_DEF,
   parameter int CNT_W       = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   bg_blank,
   input  logic [ROW_W-1:0]       bg_row,
   input  logic                   bg_col,
   input  logic                   bg_sclk,
   input  logic                   bg_latch,
   output logic                   row_valid,
   output logic [ROW_W-1:0]       row_idx,
   output logic [COLUMN_BITS-1:0] row_data,
   output logic                   row_len_err,
   output logic                   row_blanked,
   output logic                   frame_start,
   output logic                   active,
   output logic [CNT_W-1:0]       frame_cnt,
   output logic [CNT_W-1:0]       err_cnt
);

   // bit counter must reach COLUMN_BITS+1 (saturated "too many" marker)
   localparam int            CW      = $clog2(COLUMN_BITS + 2);
   localparam logic [CW-1:0] CNT_FULL = CW'(COLUMN_BITS);
   localparam logic [CW-1:0] CNT_SAT  = CW'(COLUMN_BITS + 1);

   logic [PIN_W-1:0] pins_async;
   logic [PIN_W-1:0] pins_sync;
   logic [PIN_W-1:0] pins_rise;
   logic             unused_rise;

   logic             sclk_rise;
   logic             latch_rise;
   logic             col_s;
   logic             blank_s;
   logic [ROW_W-1:0] row_s;

   rx_state_t              state_q;
   logic                   active_q;
   logic [COLUMN_BITS-1:0] sr_q;
   logic [COLUMN_BITS-1:0] sr_d;
   logic [CW-1:0]          bit_cnt_q;
   logic [CW-1:0]          bit_cnt_d;
   logic [COLUMN_BITS-1:0] row_data_q;
   row_meta_t              meta_q;

   assign pins_async = {bg_blank, bg_row, bg_col, bg_sclk, bg_latch};

   bargraph_sync #(.WIDTH(PIN_W)) u_sync (
      .clk     (clk),
      .rst     (rst),
      .async_i (pins_async),
      .sync_o  (pins_sync),
      .rise_o  (pins_rise)
   );

   assign sclk_rise   = pins_rise[PIN_SCLK];
   assign latch_rise  = pins_rise[PIN_LATCH];
   assign col_s       = pins_sync[PIN_COL];
   assign blank_s     = pins_sync[PIN_BLANK];
   assign row_s       = pins_sync[PIN_ROW_LO +: ROW_W];
   assign unused_rise = ^{pins_rise[PIN_W-1:PIN_COL]};

   // Shift-path next state; applied before a coincident latch so that bit is kept
   always_comb begin
      sr_d      = sr_q;
      bit_cnt_d = bit_cnt_q;
      if (sclk_rise) begin
         sr_d      = {sr_q[COLUMN_BITS-2:0], col_s};
         bit_cnt_d = (bit_cnt_q == CNT_SAT) ? CNT_SAT : bit_cnt_q + CW'(1);
      end
   end

   // Receiver FSM, shift register, bit counter and registered row outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         active_q   <= 1'b0;
         sr_q       <= '0;
         bit_cnt_q  <= '0;
         row_data_q <= '0;
         meta_q     <= '0;
      end else begin
         meta_q.valid       <= 1'b0;
         meta_q.frame_start <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (sclk_rise && !latch_rise) begin
                  state_q  <= S_SHIFT;
                  active_q <= 1'b1;
               end
            end
            S_SHIFT: begin
               if (latch_rise) begin
                  state_q  <= S_IDLE;
                  active_q <= 1'b0;
               end
            end
            default: begin
               state_q  <= S_IDLE;
               active_q <= 1'b0;
            end
         endcase
         if (latch_rise) begin
            // A latch in either state emits a row, even with zero bits shifted
            row_data_q         <= sr_d;
            meta_q.valid       <= 1'b1;
            meta_q.frame_start <= (row_s == '0);
            meta_q.idx         <= row_s;
            meta_q.len_err     <= (bit_cnt_d != CNT_FULL);
            meta_q.blanked     <= blank_s;
            sr_q               <= '0;
            bit_cnt_q          <= '0;
         end else begin
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
         end
      end
   end

   assign row_valid   = meta_q.valid;
   assign frame_start = meta_q.frame_start;
   assign row_idx     = meta_q.idx;
   assign row_len_err = meta_q.len_err;
   assign row_blanked = meta_q.blanked;
   assign row_data    = row_data_q;
   assign active      = active_q;

`ifdef BARGRAPH_RX_STATS_EN
   logic [CNT_W-1:0] frame_cnt_q;
   logic [CNT_W-1:0] err_cnt_q;

   // Frame and length-error counters, free-running with wrap
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         if (meta_q.frame_start) frame_cnt_q <= frame_cnt_q + CNT_W'(1);
         if (meta_q.valid && meta_q.len_err) err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign err_cnt   = err_cnt_q;
`else
   assign frame_cnt = '0;
   assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_bargraph_rx.sv
// Directed bench for bargraph_rx: drives the serial pins and checks each row.
// Build with +define+BARGRAPH_RX_STATS_EN to also check the counters.
module tb_bargraph_rx;

   localparam int CB = 48;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          bg_blank;
   logic [3:0]    bg_row;
   logic          bg_col;
   logic          bg_sclk;
   logic          bg_latch;
   logic          row_valid;
   logic [3:0]    row_idx;
   logic [CB-1:0] row_data;
   logic          row_len_err;
   logic          row_blanked;
   logic          frame_start;
   logic          active;
   logic [CW-1:0] frame_cnt;
   logic [CW-1:0] err_cnt;

   int n_checks = 0;
   int n_errors = 0;
   int rv_cnt   = 0;
   int fs_cnt   = 0;
   int exp_rows = 0;
   int exp_fs   = 0;

   bargraph_rx #(.COLUMN_BITS(CB), .CNT_W(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .bg_blank    (bg_blank),
      .bg_row      (bg_row),
      .bg_col      (bg_col),
      .bg_sclk     (bg_sclk),
      .bg_latch    (bg_latch),
      .row_valid   (row_valid),
      .row_idx     (row_idx),
      .row_data    (row_data),
      .row_len_err (row_len_err),
      .row_blanked (row_blanked),
      .frame_start (frame_start),
      .active      (active),
      .frame_cnt   (frame_cnt),
      .err_cnt     (err_cnt)
   );

   // clock
   always #5 clk = ~clk;

   // pulse monitor: every high sample of a strobe is counted, so a stretched
   // pulse shows up as an extra row
   always @(negedge clk) begin
      if (row_valid)   rv_cnt <= rv_cnt + 1;
      if (frame_start) fs_cnt <= fs_cnt + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic shift_bit(input logic b);
      bg_col = b;
      wait_clk(2);
      bg_sclk = 1'b1;
      wait_clk(3);
      bg_sclk = 1'b0;
      wait_clk(1);
   endtask

   task automatic shift_word(input logic [CB-1:0] w, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) shift_bit(w[i]);
   endtask

   task automatic pulse_latch();
      bg_latch = 1'b1;
      wait_clk(3);
      bg_latch = 1'b0;
      wait_clk(8);
   endtask

   // last bit shifted with sclk and latch rising together
   task automatic shift_last_with_latch(input logic b);
      bg_col = b;
      wait_clk(2);
      bg_sclk  = 1'b1;
      bg_latch = 1'b1;
      wait_clk(3);
      bg_sclk  = 1'b0;
      bg_latch = 1'b0;
      wait_clk(8);
   endtask

   task automatic expect_row(input string tag, input logic [3:0] idx, input logic [CB-1:0] data,
                             input logic err, input logic blk);
      exp_rows++;
      check({tag, ".count"},   64'(rv_cnt),      64'(exp_rows));
      check({tag, ".idx"},     64'(row_idx),     64'(idx));
      check({tag, ".data"},    64'(row_data),    64'(data));
      check({tag, ".len_err"}, 64'(row_len_err), 64'(err));
      check({tag, ".blanked"}, 64'(row_blanked), 64'(blk));
      check({tag, ".fs"},      64'(fs_cnt),      64'(exp_fs));
   endtask

   initial begin
      logic [CB-1:0] word;
      rst      = 1'b1;
      bg_blank = 1'b0;
      bg_row   = 4'd0;
      bg_col   = 1'b0;
      bg_sclk  = 1'b0;
      bg_latch = 1'b0;
      wait_clk(4);
      check("rst.row_valid", 64'(row_valid),   64'd0);
      check("rst.row_data",  64'(row_data),    64'd0);
      check("rst.row_idx",   64'(row_idx),     64'd0);
      check("rst.len_err",   64'(row_len_err), 64'd0);
      check("rst.active",    64'(active),      64'd0);
      check("rst.frame_cnt", 64'(frame_cnt),   64'd0);
      check("rst.err_cnt",   64'(err_cnt),     64'd0);
      rst = 1'b0;
      wait_clk(4);

      // 1: full 48-bit row on row 3
      bg_row = 4'd3;
      shift_word(48'hA5A5_0000_FFFF, 48);
      wait_clk(3);
      check("t1.active_shift", 64'(active), 64'd1);
      pulse_latch();
      expect_row("t1", 4'd3, 48'hA5A5_0000_FFFF, 1'b0, 1'b0);
      check("t1.active_idle", 64'(active), 64'd0);

      // 2: short row, right-aligned
      shift_word(48'hFFFF_FFFF_FFFF, 40);
      pulse_latch();
      expect_row("t2", 4'd3, 48'h00FF_FFFF_FFFF, 1'b1, 1'b0);
`ifdef BARGRAPH_RX_STATS_EN
      check("t2.err_cnt", 64'(err_cnt), 64'd1);
`else
      check("t2.err_cnt", 64'(err_cnt), 64'd0);
`endif

      // 3: long row keeps the last 48 bits
      shift_word(48'h0, 2);
      shift_word(48'hFFFF_FFFF_FFFF, 48);
      pulse_latch();
      expect_row("t3", 4'd3, 48'hFFFF_FFFF_FFFF, 1'b1, 1'b0);

      // 4a: latch with no bits
      pulse_latch();
      expect_row("t4a", 4'd3, 48'h0, 1'b1, 1'b0);

      // 4b: 48th bit coincides with latch
      word = 48'h8123_4567_89AB;
      shift_word(word >> 1, 47);
      shift_last_with_latch(word[0]);
      expect_row("t4b", 4'd3, word, 1'b0, 1'b0);

      // 5: two frames of rows 0..15, blank only on row 5
      for (int f = 0; f < 2; f++) begin
         for (int r = 0; r < 16; r++) begin
            bg_row   = 4'(r);
            bg_blank = (r == 5);
            word     = {12{4'(r)}};
            shift_word(word, 48);
            pulse_latch();
            if (r == 0) exp_fs++;
            expect_row($sformatf("t5.f%0d.r%0d", f, r), 4'(r), word, 1'b0, (r == 5));
         end
      end
      bg_blank = 1'b0;
`ifdef BARGRAPH_RX_STATS_EN
      check("t5.frame_cnt", 64'(frame_cnt), 64'd2);
      check("t5.err_cnt",   64'(err_cnt),   64'd3);
`else
      check("t5.frame_cnt", 64'(frame_cnt), 64'd0);
`endif

      // 6: reset in the middle of a row, then a clean row
      bg_row = 4'd9;
      shift_word(48'hFFFF_FFFF_FFFF, 20);
      rst = 1'b1;
      wait_clk(3);
      check("t6.rst_active", 64'(active),    64'd0);
      check("t6.rst_valid",  64'(row_valid), 64'd0);
      check("t6.rst_stats",  64'(frame_cnt), 64'd0);
      rst = 1'b0;
      wait_clk(4);
      check("t6.no_row", 64'(rv_cnt), 64'(exp_rows));
      word = 48'h1357_9BDF_0246;
      shift_word(word, 48);
      pulse_latch();
      expect_row("t6", 4'd9, word, 1'b0, 1'b0);
      check("t6.err_cnt", 64'(err_cnt), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
